// File: rtl/cinnabon_fpga_qsys_input_conditioner.sv
// cinnabon_fpga_qsys_input_conditioner
// Resynchronises and debounces each bit of the raw board inputs that feed
// the Qsys PIO in_port. It also produces registered per-bit rise/fall pulses.
// Optional sticky rising-edge capture with an interrupt output is enabled by
// defining CINNABON_INPUT_EDGE_CAPTURE_EN. The port list is identical either
// way; with the macro undefined the capture outputs are constant 0.
module cinnabon_fpga_qsys_input_conditioner #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  input  logic [WIDTH-1:0] capture_clear,
  output logic [WIDTH-1:0] edge_capture,
  output logic             capture_irq
);

  // The count at which a persistent mismatch is accepted. The counter never
  // exceeds this value, so it cannot wrap.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     sync_p0;
  logic [WIDTH-1:0]     sync_p1;
  logic [CNT_WIDTH-1:0] cnt_p2 [WIDTH];

  // Stage p0/p1: two-flop synchroniser per bit, with no logic between the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: independent debounce per bit. The level and its pulses update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_p2[i] <= '0;
      end
    end else begin
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_p1[i] == level_out[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          level_out[i]  <= sync_p1[i];
          rise_pulse[i] <= sync_p1[i];
          fall_pulse[i] <= ~sync_p1[i];
          cnt_p2[i]     <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

`ifdef CINNABON_INPUT_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] capture_p3;
  logic             irq_p4;

  // Stage p3/p4: sticky rise flags (set beats clear), then a registered OR for the IRQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture_p3 <= '0;
      irq_p4     <= 1'b0;
    end else begin
      capture_p3 <= (capture_p3 & ~capture_clear) | rise_pulse;
      irq_p4     <= |capture_p3;
    end
  end

  assign edge_capture = capture_p3;
  assign capture_irq  = irq_p4;
`else
  // Capture is disabled. capture_clear is reduced only so that the input is not left dangling.
  logic unused_capture_clear;
  assign unused_capture_clear = ^capture_clear;
  assign edge_capture = '0;
  assign capture_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_cinnabon_fpga_qsys_input_conditioner.sv
// Bench for cinnabon_fpga_qsys_input_conditioner (DEBOUNCE_CYCLES=4).
// Expected level/pulse events are queued by the stimulus together with the
// clock edge on which they must appear. The monitor pops and checks them,
// and it requires quiet outputs and a stable level on every other cycle.
module tb_cinnabon_fpga_qsys_input_conditioner;
  localparam int W   = 16;
  localparam int D   = 4;
  localparam int LAT = D + 2;

  typedef struct {
    int          cyc;
    logic [15:0] level;
    logic [15:0] rise;
    logic [15:0] fall;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  raw_in = '0;
  logic [W-1:0]  capture_clear = '0;
  logic [W-1:0]  level_out, rise_pulse, fall_pulse, edge_capture;
  logic          capture_irq;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  ev_t  q[$];
  logic [15:0] lvl_model = '0;

  cinnabon_fpga_qsys_input_conditioner #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .capture_clear(capture_clear), .edge_capture(edge_capture),
    .capture_irq(capture_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int dly, input logic [15:0] lv,
                           input logic [15:0] r, input logic [15:0] f);
    ev_t e;
    e.cyc = cyc + dly; e.level = lv; e.rise = r; e.fall = f;
    q.push_back(e);
  endtask

  // Monitor: checks each cycle on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rise_fall_overlap", {16'h0, rise_pulse & fall_pulse}, 32'h0);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev_t e;
        e = q.pop_front();
        chk("ev_level", {16'h0, level_out}, {16'h0, e.level});
        chk("ev_rise",  {16'h0, rise_pulse}, {16'h0, e.rise});
        chk("ev_fall",  {16'h0, fall_pulse}, {16'h0, e.fall});
        lvl_model = e.level;
      end else begin
        chk("spurious_pulse", {rise_pulse, fall_pulse}, 32'h0);
        chk("level_stable", {16'h0, level_out}, {16'h0, lvl_model});
      end
`ifndef CINNABON_INPUT_EDGE_CAPTURE_EN
      chk("capture_off", {15'h0, capture_irq, edge_capture}, 32'h0);
`endif
    end
  end

  initial begin
    // Check the reset state.
    step(3);
    chk("rst_level", {16'h0, level_out}, 32'h0);
    chk("rst_pulses", {rise_pulse, fall_pulse}, 32'h0);
    chk("rst_capture", {15'h0, capture_irq, edge_capture}, 32'h0);
    reset = 1'b0;
    step(3);
    mon_en = 1'b1;

    // Single-bit rise, then fall, on bit 0.
    raw_in = 16'h0001; expect_ev(LAT, 16'h0001, 16'h0001, 16'h0000);
    step(10);
    raw_in = 16'h0000; expect_ev(LAT, 16'h0000, 16'h0000, 16'h0001);
    step(10);

    // A 3-cycle glitch on bit 5 is rejected.
    raw_in = 16'h0020;
    step(3);
    raw_in = 16'h0000;
    step(10);
    // A 4-cycle pulse on bit 5 just qualifies.
    raw_in = 16'h0020; expect_ev(LAT, 16'h0020, 16'h0020, 16'h0000);
    step(4);
    raw_in = 16'h0000; expect_ev(LAT, 16'h0000, 16'h0000, 16'h0020);
    step(12);

    // All bits change together.
    raw_in = 16'hFFFF; expect_ev(LAT, 16'hFFFF, 16'hFFFF, 16'h0000);
    step(10);
    raw_in = 16'h0000; expect_ev(LAT, 16'h0000, 16'h0000, 16'hFFFF);
    step(10);

    // Reset mid-count on bit 2 (cnt=2), then full re-qualification.
    raw_in = 16'h0004;
    step(4);
    reset = 1'b1;
    step(1);
    chk("midrst_level", {16'h0, level_out}, 32'h0);
    reset = 1'b0; expect_ev(LAT, 16'h0004, 16'h0004, 16'h0000);
    step(10);
    raw_in = 16'h0000; expect_ev(LAT, 16'h0000, 16'h0000, 16'h0004);
    step(10);

    // Rise on bit 3 with the edge capture/clear sequence.
    raw_in = 16'h0008; expect_ev(LAT, 16'h0008, 16'h0008, 16'h0000);
    step(LAT + 1);
`ifdef CINNABON_INPUT_EDGE_CAPTURE_EN
    chk("cap_set", {16'h0, edge_capture}, 32'h0008);
`endif
    step(1);
`ifdef CINNABON_INPUT_EDGE_CAPTURE_EN
    chk("cap_irq", {31'h0, capture_irq}, 32'h1);
`endif
    capture_clear = 16'h0008;
    step(1);
    capture_clear = 16'h0000;
`ifdef CINNABON_INPUT_EDGE_CAPTURE_EN
    chk("cap_clear", {16'h0, edge_capture}, 32'h0);
`endif
    step(2);
    raw_in = 16'h0000; expect_ev(LAT, 16'h0000, 16'h0000, 16'h0008);
    step(10);
    raw_in = 16'h0008; expect_ev(LAT, 16'h0008, 16'h0008, 16'h0000);
    step(LAT);
    capture_clear = 16'h0008;
    step(1);
    capture_clear = 16'h0000;
`ifdef CINNABON_INPUT_EDGE_CAPTURE_EN
    chk("cap_set_wins", {16'h0, edge_capture}, 32'h0008);
`endif
    step(5);
    raw_in = 16'h0000; expect_ev(LAT, 16'h0000, 16'h0000, 16'h0008);
    step(10);

    mon_en = 1'b0;
    chk("queue_drained", q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cinnabon_fpga_qsys_input_conditioner.md
Name: cinnabon_fpga_qsys_input_conditioner

Overview:
Upstream conditioner for the 16-bit Qsys PIO input port. Takes raw asynchronous board inputs (buttons, sensor strobes) and resynchronises each bit to clk. Debounces each bit independently and drives a clean level bus straight into the PIO's in_port. Also emits per-bit rise/fall pulses for local logic, so level-sensitive PIO interrupts never see glitches.

Parameters:
WIDTH, 16, number of independent input bits; matches PIO in_port width.
DEBOUNCE_CYCLES, 1000, consecutive clk cycles a synchronised input must differ from the held level before the level flips; legal range 1..2^CNT_WIDTH.
CNT_WIDTH, 16, per-bit debounce counter width.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
raw_in  input  WIDTH  asynchronous raw inputs.
level_out  output  WIDTH  debounced level; connects to PIO in_port.
rise_pulse  output  WIDTH  one-cycle pulse per bit when level_out goes 0->1.
fall_pulse  output  WIDTH  one-cycle pulse per bit when level_out goes 1->0.
capture_clear  input  WIDTH  per-bit clear for edge_capture (used only with the optional feature).
edge_capture  output  WIDTH  sticky rising-edge flags (optional feature).
capture_irq  output  1  OR of edge_capture (optional feature).

Behaviour:
- Single clock domain is clk. Reset is synchronous and active-high, sampled on the clk rising edge. All registers are reset on that edge.
- Reset values: sync stages 0, level_out 0, counters 0, rise_pulse 0, fall_pulse 0, edge_capture 0, capture_irq 0.
- Synchroniser: two flops per bit, s1 <= raw_in, s2 <= s1. No logic between the two stages.
- Per-bit debounce, evaluated every edge:
  - If s2 == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= s2, cnt <= 0, and the matching rise/fall pulse is asserted for exactly the next cycle.
  - Else: cnt <= cnt+1.
- Latency: raw_in is first captured into s1 on edge 1. level_out flips on edge DEBOUNCE_CYCLES+2. With DEBOUNCE_CYCLES=1 that is edge 3.
- Glitch rejection: a mismatch shorter than DEBOUNCE_CYCLES consecutive evaluated cycles resets cnt. level_out and pulses do not change.
- Pulses are registered, aligned to the cycle in which level_out shows the new value, and never both high on one bit.
- Bits are fully independent. Simultaneous transitions on several bits give simultaneous pulses.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Reset asserted mid-debounce discards the in-progress count and clears level_out to 0. After reset releases, an input held high is re-qualified through the full latency.
- level_out is a registered output with no combinational path from raw_in.

Optional Feature:
Macro: CINNABON_INPUT_EDGE_CAPTURE_EN.
- Defined:
  - edge_capture[i] sets when rise_pulse[i] is high.
  - edge_capture[i] clears when capture_clear[i] is high on an edge.
  - Set wins if set and clear land on the same edge.
  - capture_irq is the registered OR of edge_capture, so it lags edge_capture by one cycle.
- Undefined: edge_capture and capture_irq are tied to 0, capture_clear is ignored, and no capture registers are inferred. The port list is identical in both builds.

Test Plan:
1. DEBOUNCE_CYCLES=4, reset, then raw_in[0] 0->1 and held -> level_out[0]=1 on edge 6 after the change; rise_pulse[0] high exactly that cycle; all other bits stay 0.
2. DEBOUNCE_CYCLES=4, 3-cycle high glitch on raw_in[5] -> level_out[5] stays 0; no rise_pulse or fall_pulse on any bit.
3. raw_in=16'hFFFF held until level_out=16'hFFFF, then raw_in=16'h0000 -> fall_pulse=16'hFFFF for one cycle, level_out=16'h0000.
4. Reset asserted for 1 cycle while raw_in[2] is mid-count (cnt=2) -> level_out=0, no pulse; after release with raw_in[2] still high, level_out[2] rises after a full DEBOUNCE_CYCLES+2 edges.
5. With CINNABON_INPUT_EDGE_CAPTURE_EN: rise on bit 3 -> edge_capture=16'h0008, capture_irq=1 next cycle; capture_clear[3] pulse -> edge_capture=0; clear coincident with a new rise -> edge_capture[3] stays 1.
6. Without the macro: same stimulus as scenario 5 -> edge_capture=0 and capture_irq=0 throughout; level_out and pulses identical to scenario 1.
